// File: rtl/command_translator_if.sv
// Byte-stream link between the command decoder and the JSON frame translator.
// The master drives a command and a valid request. The slave returns one frame character per cycle.
interface command_translator_if;
  logic [2:0] command;
  logic       valid;
  logic [7:0] ascii_out;
  logic       tx_ready;

  modport master (
    output command,
    output valid,
    input  ascii_out,
    input  tx_ready
  );

  modport slave (
    input  command,
    input  valid,
    output ascii_out,
    output tx_ready
  );
endinterface

// File: rtl/command_translator.sv
// Turns a 3-bit motion command into a 25-character JSON frame such as {"T":1,"L":0.50,"R":0.50}.
// The frame is sent one byte per clock toward the UART transmitter.
module command_translator (
  input logic               clk,
  input logic               rst_n,
  command_translator_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [4:0] LastIdx = 5'd24;

  state_t      state_q;
  logic [2:0]  latchedCmd_q;
  logic [4:0]  charIdx_q;
  logic [7:0]  ascii_q;
  logic        txReady_q;

  logic [3:0]  tDig_d;
  logic [3:0]  l0Dig_d, l1Dig_d, l2Dig_d;
  logic [3:0]  r0Dig_d, r1Dig_d, r2Dig_d;
  logic [7:0]  nextChar_d;

  // Map the latched command to its decimal digits. Unknown codes fall back to stop.
  always_comb begin
    tDig_d  = 4'd0;
    l0Dig_d = 4'd0;
    l1Dig_d = 4'd0;
    l2Dig_d = 4'd0;
    r0Dig_d = 4'd0;
    r1Dig_d = 4'd0;
    r2Dig_d = 4'd0;
    case (latchedCmd_q)
      3'd0: begin
        tDig_d  = 4'd1;
        l1Dig_d = 4'd5;
        r1Dig_d = 4'd5;
      end
      3'd2: begin
        tDig_d  = 4'd1;
        l1Dig_d = 4'd2;
        l2Dig_d = 4'd5;
        r1Dig_d = 4'd5;
      end
      3'd3: begin
        tDig_d  = 4'd1;
        l1Dig_d = 4'd5;
        r1Dig_d = 4'd2;
        r2Dig_d = 4'd5;
      end
      3'd4: begin
        tDig_d  = 4'd1;
        l0Dig_d = 4'd1;
        r0Dig_d = 4'd1;
      end
      default: begin
        tDig_d  = 4'd0;
      end
    endcase
  end

  always_comb begin
    nextChar_d = 8'h00;
    case (charIdx_q)
      5'd0:    nextChar_d = "{";
      5'd1:    nextChar_d = "\"";
      5'd2:    nextChar_d = "T";
      5'd3:    nextChar_d = "\"";
      5'd4:    nextChar_d = ":";
      5'd5:    nextChar_d = 8'h30 | {4'h0, tDig_d};
      5'd6:    nextChar_d = ",";
      5'd7:    nextChar_d = "\"";
      5'd8:    nextChar_d = "L";
      5'd9:    nextChar_d = "\"";
      5'd10:   nextChar_d = ":";
      5'd11:   nextChar_d = 8'h30 | {4'h0, l0Dig_d};
      5'd12:   nextChar_d = ".";
      5'd13:   nextChar_d = 8'h30 | {4'h0, l1Dig_d};
      5'd14:   nextChar_d = 8'h30 | {4'h0, l2Dig_d};
      5'd15:   nextChar_d = ",";
      5'd16:   nextChar_d = "\"";
      5'd17:   nextChar_d = "R";
      5'd18:   nextChar_d = "\"";
      5'd19:   nextChar_d = ":";
      5'd20:   nextChar_d = 8'h30 | {4'h0, r0Dig_d};
      5'd21:   nextChar_d = ".";
      5'd22:   nextChar_d = 8'h30 | {4'h0, r1Dig_d};
      5'd23:   nextChar_d = 8'h30 | {4'h0, r2Dig_d};
      5'd24:   nextChar_d = "}";
      default: nextChar_d = 8'h00;
    endcase
  end

  // The command is captured only at frame start, so a mid-frame change cannot mix two frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      latchedCmd_q <= 3'd1;
      charIdx_q    <= 5'd0;
      ascii_q      <= 8'h00;
      txReady_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ascii_q   <= 8'h00;
          txReady_q <= 1'b0;
          charIdx_q <= 5'd0;
          if (bus.valid) begin
            latchedCmd_q <= bus.command;
            ascii_q      <= "{";
            txReady_q    <= 1'b1;
            charIdx_q    <= 5'd1;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (charIdx_q > LastIdx) begin
            ascii_q   <= 8'h00;
            txReady_q <= 1'b0;
            charIdx_q <= 5'd0;
            state_q   <= IDLE;
          end else begin
            ascii_q   <= nextChar_d;
            txReady_q <= 1'b1;
            charIdx_q <= charIdx_q + 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ascii_out = ascii_q;
  assign bus.tx_ready  = txReady_q;

endmodule

// File: tb/tb_command_translator.sv
// Directed scoreboard bench for command_translator.
// Expected frame bytes are queued when a command is driven and popped as the DUT emits them.
module tb_command_translator;

  logic clk = 1'b0;
  logic rst_n;

  command_translator_if bus ();

  command_translator dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ[$];

  function automatic string frameText(input logic [2:0] cmd);
    case (cmd)
      3'd0:    return "{\"T\":1,\"L\":0.50,\"R\":0.50}";
      3'd2:    return "{\"T\":1,\"L\":0.25,\"R\":0.50}";
      3'd3:    return "{\"T\":1,\"L\":0.50,\"R\":0.25}";
      3'd4:    return "{\"T\":1,\"L\":1.00,\"R\":1.00}";
      default: return "{\"T\":0,\"L\":0.00,\"R\":0.00}";
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] cmd);
    string s;
    s = frameText(cmd);
    bus.command = cmd;
    bus.valid   = 1'b1;
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
  endtask

  // Waits for the frame, then compares nBytes bytes. changeAt and dropAt give the byte after which
  // the command is changed or valid is dropped. A value of 0 disables that action.
  task automatic checkOutput(input int nBytes, input int changeAt, input logic [2:0] newCmd,
                             input int dropAt);
    int latency;
    logic [7:0] e;
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
    end while (bus.tx_ready !== 1'b1 && latency < 5);
    checkVal("startLatency", latency, 1);
    if (bus.tx_ready !== 1'b1) begin
      expQ.delete();
      return;
    end
    for (int i = 0; i < nBytes; i++) begin
      if (i > 0) @(negedge clk);
      if (expQ.size() == 0) begin
        checkVal("queueEmpty", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkVal($sformatf("byte%0d", i), {24'h0, bus.ascii_out}, {24'h0, e});
      end
      checkVal($sformatf("txReady%0d", i), {31'h0, bus.tx_ready}, 1);
      if (i + 1 == changeAt) bus.command = newCmd;
      if (i + 1 == dropAt) bus.valid = 1'b0;
    end
    if (nBytes == 25) begin
      @(negedge clk);
      checkVal("gapTxReady", {31'h0, bus.tx_ready}, 0);
      checkVal("gapAscii", {24'h0, bus.ascii_out}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    bus.command = 3'd0;
    bus.valid   = 1'b0;
    #12;
    checkVal("resetTxReady", {31'h0, bus.tx_ready}, 0);
    checkVal("resetAscii", {24'h0, bus.ascii_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(3'd0);
    checkOutput(25, 0, 3'd0, 0);
    applyStimulus(3'd1);
    checkOutput(25, 0, 3'd0, 0);
    applyStimulus(3'd7);
    checkOutput(25, 0, 3'd0, 0);

    applyStimulus(3'd0);
    checkOutput(25, 20, 3'd1, 0);
    applyStimulus(3'd1);
    checkOutput(25, 0, 3'd0, 0);

    applyStimulus(3'd2);
    checkOutput(25, 0, 3'd0, 0);
    applyStimulus(3'd3);
    checkOutput(25, 0, 3'd0, 0);
    applyStimulus(3'd4);
    checkOutput(25, 0, 3'd0, 0);

    applyStimulus(3'd0);
    checkOutput(25, 0, 3'd0, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("idleTxReady", {31'h0, bus.tx_ready}, 0);
      checkVal("idleAscii", {24'h0, bus.ascii_out}, 0);
    end
    checkVal("queueDrained", expQ.size(), 0);

    applyStimulus(3'd3);
    checkOutput(10, 0, 3'd0, 0);
    rst_n = 1'b0;
    #1;
    checkVal("abortTxReady", {31'h0, bus.tx_ready}, 0);
    checkVal("abortAscii", {24'h0, bus.ascii_out}, 0);
    expQ.delete();
    @(negedge clk);
    checkVal("heldTxReady", {31'h0, bus.tx_ready}, 0);
    rst_n = 1'b1;
    applyStimulus(3'd4);
    checkOutput(25, 0, 3'd0, 0);
    bus.valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
